// File: rtl/counter_cmd_seq_if.sv
// Command handshake bundle between an upstream command source and the
// counter command sequencer: valid/ready plus opcode and argument.
interface counter_cmd_seq_if #(
  parameter int W = 8
);
  logic         cmd_valid;
  logic         cmd_ready;
  logic [1:0]   cmd_op;
  logic [W-1:0] cmd_arg;

  modport master (
    output cmd_valid,
    output cmd_op,
    output cmd_arg,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_op,
    input  cmd_arg,
    output cmd_ready
  );
endinterface

// File: rtl/counter_cmd_seq.sv
// Command sequencer feeding an 8-bit load/inc/dec/clear counter.
// Commands are queued in a small FIFO, INC/DEC are expanded into N counter
// operations, and between commands the counter is held by loading its own
// output back (the counter has no hold opcode).
module counter_cmd_seq #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  counter_cmd_seq_if.slave     cmd,
  input  logic [W-1:0]         cnt_q,
  output logic [1:0]           c,
  output logic [W-1:0]         din,
  output logic                 busy,
  output logic                 done
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_INC   = 2'b01;
  localparam logic [1:0] OP_DEC   = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  localparam logic [W-1:0] ONE = W'(1);

  typedef enum logic {S_IDLE, S_EXEC} state_t;

  // FIFO storage and pointers; pointers carry one extra wrap bit so that
  // full and empty can be told apart with equal low bits.
  logic [W+1:0] r_mem [DEPTH];
  logic [AW:0]  r_wr;
  logic [AW:0]  r_rd;

  logic         w_full;
  logic         w_empty;
  logic         w_push;
  logic         w_pop;
  logic [1:0]   w_head_op;
  logic [W-1:0] w_head_arg;
  logic         w_head_counts;

  state_t       r_state;
  state_t       w_state_nxt;

  logic [1:0]   op_r;
  logic [W-1:0] arg_r;
  logic [W-1:0] rem_r;
  logic         r_done;

  logic         w_counts;
  logic         w_last;

  assign w_empty       = (r_wr == r_rd);
  assign w_full        = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
  assign w_push        = cmd.cmd_valid && !w_full;
  assign cmd.cmd_ready = !w_full;

  assign w_head_op     = r_mem[r_rd[AW-1:0]][W+1:W];
  assign w_head_arg    = r_mem[r_rd[AW-1:0]][W-1:0];
  assign w_head_counts = (w_head_op == OP_INC) || (w_head_op == OP_DEC);

  // INC/DEC repeat; LOAD and CLEAR run exactly once (rem_r starts at 1).
  assign w_counts = (op_r == OP_INC) || (op_r == OP_DEC);
  // rem_r of 1 is the last issue cycle; 0 is the single hold cycle of a
  // zero-count INC/DEC. Either way this is the command's final EXEC cycle.
  assign w_last   = (rem_r <= ONE);

  assign busy = (r_state == S_EXEC) || !w_empty;
  assign done = r_done;

  // Write queued commands; the payload needs no reset, only the pointers do.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr[AW-1:0]] <= {cmd.cmd_op, cmd.cmd_arg};
    end
  end

  // Advance FIFO pointers on push/pop; reset discards queued commands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next state, pop decision and counter drive; default is hold (load cnt_q).
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    c           = OP_LOAD;
    din         = cnt_q;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = S_EXEC;
        end
      end
      S_EXEC: begin
        if (w_counts) begin
          if (rem_r != '0) begin
            c   = op_r;
            din = arg_r;
          end
        end else if (op_r == OP_LOAD) begin
          c   = OP_LOAD;
          din = arg_r;
        end else begin
          c   = OP_CLEAR;
          din = arg_r;
        end
        if (w_last) begin
          if (!w_empty) w_pop       = 1'b1;
          else          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Capture the popped command, or count down the remaining repeats.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_r  <= OP_LOAD;
      arg_r <= '0;
      rem_r <= '0;
    end else if (w_pop) begin
      op_r  <= w_head_op;
      arg_r <= w_head_arg;
      rem_r <= w_head_counts ? w_head_arg : ONE;
    end else if ((r_state == S_EXEC) && (rem_r != '0)) begin
      rem_r <= rem_r - ONE;
    end
  end

  // done pulses in the cycle after a command's final EXEC cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_done <= 1'b0;
    else     r_done <= (r_state == S_EXEC) && w_last;
  end

endmodule

// File: doc/counter_cmd_seq.md
# counter_cmd_seq

Command sequencer that sits directly upstream of the 8-bit load/inc/dec/clear counter and drives its `c`/`din` control inputs. It accepts queued commands over a valid/ready handshake, expands INC/DEC commands into N consecutive counter operations, and holds the counter's value between commands. Hold works by driving a LOAD of the counter's own output, because the counter has no hold opcode.

## Interface
- `DEPTH`, 4: command FIFO depth; power of two, ≥2.
- `W`, 8: data width; matches the counter width.

- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  FIFO can accept; `cmd_ready = !full`.
- `cmd_op`  in  2  00 LOAD, 01 INC, 10 DEC, 11 CLEAR.
- `cmd_arg`  in  W  LOAD: value to load. INC/DEC: repeat count N. CLEAR: ignored.
- `cnt_q`  in  W  counter `dout`, fed back for hold.
- `c`  out  2  counter opcode.
- `din`  out  W  counter load data.
- `busy`  out  1  high while executing or while the FIFO is non-empty.
- `done`  out  1  one-cycle pulse when a command completes.

## Operation
- FIFO:
  - Push when `cmd_valid & cmd_ready` at a clock edge; stores {op, arg}.
  - No push when full; the command stays pending and the upstream holds it.
  - Push and pop in the same edge are both legal when non-full.
- FSM states: IDLE, EXEC. Registers: `op_r` (2b), `arg_r` (W), `rem_r` (W).
- IDLE:
  - FIFO empty: stay.
  - FIFO non-empty: pop head, load `op_r`/`arg_r`, set `rem_r` = arg (INC/DEC) or 1 (LOAD/CLEAR), go EXEC.
- EXEC, per cycle:
  - INC/DEC with `rem_r` ≥ 1: drive `c=op_r`, decrement `rem_r`.
  - INC/DEC with N=0: one hold cycle, no counting.
  - LOAD: drive `c=00`, `din=arg_r` for one cycle.
  - CLEAR: drive `c=11` for one cycle.
- Last EXEC cycle: FIFO non-empty → pop next and stay in EXEC, no bubble. FIFO empty → go to IDLE.
- Hold, whenever not issuing an operation (IDLE, reset, N=0 cycle): `c=00`, `din=cnt_q`. This output is combinational from `cnt_q`; the path has no loop because `cnt_q` is a register output.
- Outside LOAD/hold cycles, `din` = `arg_r`. Value is don't-care to the counter but must be deterministic.
- Arithmetic: `rem_r` counts down modulo 2^W and never wraps below 0. The counter itself wraps modulo 2^W; the sequencer does not saturate or check the counter value.
- `done`: registered. High for exactly one cycle after the edge that ends a command's last EXEC cycle, i.e. the first cycle in which `cnt_q` shows the command's final value.
- Reset (asserted at any time, including mid-command):
  - FIFO emptied, queued commands discarded.
  - State IDLE; `op_r`/`arg_r`/`rem_r` = 0.
  - `done=0`, `busy=0`, `cmd_ready=1`, `c=00`, `din=cnt_q`.
  - Normal operation resumes on the first edge after deassertion.

## Timing
- Acceptance edge T, FSM idle, FIFO empty:
  - Pop at edge T+1; `c` shows the op during cycle T+1..T+2.
  - Counter samples it at edge T+2.
  - Latency from acceptance to first counter update: 2 edges.
- INC/DEC N≥1: exactly N consecutive cycles of `c=op`. Counter changes by ±N.
- Command occupancy in EXEC:
  - LOAD, CLEAR and zero-count INC/DEC: 1 cycle each.
  - INC/DEC N≥1: N cycles.
- Back-to-back commands: zero idle cycles between them.
- `done` rises 1 edge after the last issue cycle.
- Capacity: DEPTH queued commands plus 1 executing. `cmd_ready` deasserts the cycle after the DEPTH-th queued push. It reasserts the cycle after the next pop.

## Test plan
- Reset then release, `cnt_q` driven by the counter → `cmd_ready=1`, `busy=0`, `done=0`, `c=00`, `din==cnt_q` every cycle; counter stays 0.
- LOAD 25 then INC 3 pushed on consecutive cycles → counter 25, 26, 27, 28 on consecutive edges. `c=01` for exactly 3 cycles, two `done` pulses, final 28, `busy` drops after.
- LOAD 250, INC 10 → counter wraps through 255, 0 and ends at 4. DEC 5 → ends at 255.
- INC 0, then CLEAR → one hold cycle with counter unchanged and `done` pulse, then counter 0, second `done`.
- Push DEPTH+2 INC 255 commands with `cmd_valid` held high → 1 executing + DEPTH queued. `cmd_ready` low with the last command pending until the first command completes. All commands execute in order; final count = 255·(DEPTH+2) mod 256.
- Assert `rst` mid-way through INC 100 with 2 commands queued → outputs go to reset values immediately (asynchronous). After release the counter holds and no queued command executes.
